// File: rtl/attenuator_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// attenuator_arbiter_pkg
// Shared constants and helpers for the attenuator arbiter slice.
// Holds no typedefs. The word width, requester count and latency stay module
// parameters.
//   PTR_W    : width of the round-robin pointer (covers up to 8 requesters)
//   STAT_W   : width of the per-frame grant statistics counter
//   slice_lo : low bit index of requester slice idx in a packed bus
// -----------------------------------------------------------------------------
package attenuator_arbiter_pkg;

   localparam int PTR_W  = 3;
   localparam int STAT_W = 8;

   // Low bit of requester idx within a bus made of width-bit slices
   function automatic int slice_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/attenuator.sv
// -----------------------------------------------------------------------------
// attenuator
// Saturating signed attenuator. The result is sample * att / 2^(BITSIZE-1).
// att is an unsigned Q1.(BITSIZE-1) gain: 0x8000 = 1.0 and 0x4000 = 0.5 at
// 16 bits. The result is clipped to the signed BITSIZE range. It appears LAT
// clock cycles after the operands are presented.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset, clears the result pipeline
//   sample in   signed operand
//   att    in   unsigned attenuation factor
//   result out  signed saturated result (registered, LAT stages)
// -----------------------------------------------------------------------------
module attenuator #(
   parameter int BITSIZE = 16,
   parameter int LAT     = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic signed [BITSIZE-1:0] sample,
   input  logic        [BITSIZE-1:0] att,
   output logic signed [BITSIZE-1:0] result
);

   // 2*BITSIZE+1 bits hold the full signed product of a signed and an unsigned word
   localparam int PW = 2 * BITSIZE + 1;
   localparam logic signed [PW-1:0] MAX_V = {{(PW-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
   localparam logic signed [PW-1:0] MIN_V = {{(PW-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};

   logic signed [PW-1:0]      sample_ext_s;
   logic signed [PW-1:0]      att_ext_s;
   logic signed [PW-1:0]      prod_s;
   logic signed [PW-1:0]      scaled_s;
   logic signed [BITSIZE-1:0] sat_s;
   logic signed [BITSIZE-1:0] pipe_r [LAT];

   // Full-precision product, rescale, then clip to the output range
   always_comb begin
      sample_ext_s = $signed({{(PW-BITSIZE){sample[BITSIZE-1]}}, sample});
      att_ext_s    = $signed({{(PW-BITSIZE){1'b0}}, att});
      prod_s       = sample_ext_s * att_ext_s;
      scaled_s     = prod_s >>> (BITSIZE - 1);
      if (scaled_s > MAX_V) begin
         sat_s = MAX_V[BITSIZE-1:0];
      end else if (scaled_s < MIN_V) begin
         sat_s = MIN_V[BITSIZE-1:0];
      end else begin
         sat_s = scaled_s[BITSIZE-1:0];
      end
   end

   // Result pipeline; stage 0 registers the saturated value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < LAT; k++) begin
            pipe_r[k] <= {BITSIZE{1'b0}};
         end
      end else begin
         pipe_r[0] <= sat_s;
         for (int k = 1; k < LAT; k++) begin
            pipe_r[k] <= pipe_r[k-1];
         end
      end
   end

   assign result = pipe_r[LAT-1];

endmodule

// File: rtl/attenuator_arbiter.sv
// -----------------------------------------------------------------------------
// attenuator_arbiter
// Shares one attenuator (instance A1) among NREQ requesters. Round-robin
// arbitration issues at most one grant per cycle. A requester is masked for
// the cycle its own gnt is high. The pointer restarts at 0 on each frame
// start, which is the rising edge of lrclk. A one-hot tag travels alongside
// the attenuator pipeline, so rsp_valid marks which requester owns rsp_data.
// Optional feature: define ATTENUATOR_ARBITER_STATS_EN to count grants per
// frame. The count saturates at 255 and is latched into grant_count at each
// frame start. Without it, grant_count is 0.
// Ports:
//   bclk        in   sole clock, rising edge
//   rst         in   asynchronous active-high reset
//   lrclk       in   frame clock level, sampled on bclk
//   req         in   [NREQ]          requests, held until granted
//   op_in       in   [NREQ*BITSIZE]  signed operands, requester i at slice i
//   op_att      in   [NREQ*BITSIZE]  attenuation factors, requester i at slice i
//   gnt         out  [NREQ]          one-hot grant pulse (registered)
//   rsp_valid   out  [NREQ]          one-hot result strobe (registered)
//   rsp_data    out  [BITSIZE]       signed attenuated result
//   busy        out  any result in flight (registered)
//   overrun     out  sticky: a request was pending at a frame start
//   grant_count out  [8]             grants issued in the previous frame
// -----------------------------------------------------------------------------
module attenuator_arbiter
   import attenuator_arbiter_pkg::*;
#(
   parameter int BITSIZE = 16,
   parameter int NREQ    = 4,
   parameter int LAT     = 1
) (
   input  logic                      bclk,
   input  logic                      rst,
   input  logic                      lrclk,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*BITSIZE-1:0]   op_in,
   input  logic [NREQ*BITSIZE-1:0]   op_att,
   output logic [NREQ-1:0]           gnt,
   output logic [NREQ-1:0]           rsp_valid,
   output logic signed [BITSIZE-1:0] rsp_data,
   output logic                      busy,
   output logic                      overrun,
   output logic [STAT_W-1:0]         grant_count
);

   logic                      lrclk_r;
   logic                      frame_start_s;
   logic [NREQ-1:0]           eligible_s;
   logic [NREQ-1:0]           grant_s;
   logic                      found_s;
   logic [PTR_W-1:0]          ptr_r;
   logic [PTR_W-1:0]          eff_ptr_s;
   logic [PTR_W-1:0]          win_s;
   logic [PTR_W-1:0]          ptr_next_s;
   logic signed [BITSIZE-1:0] sel_in_s;
   logic [BITSIZE-1:0]        sel_att_s;
   logic signed [BITSIZE-1:0] mul_in_r;
   logic [BITSIZE-1:0]        mul_att_r;
   logic [NREQ-1:0]           tag_r [LAT];
   logic                      busy_next_s;

   assign frame_start_s = lrclk & ~lrclk_r;

   // Round-robin search from the effective pointer; a frame start forces pointer 0
   always_comb begin
      eligible_s = req & ~gnt;
      eff_ptr_s  = frame_start_s ? {PTR_W{1'b0}} : ptr_r;
      found_s    = 1'b0;
      win_s      = {PTR_W{1'b0}};
      for (int k = 0; k < NREQ; k++) begin
         if (!found_s && eligible_s[(int'(eff_ptr_s) + k) % NREQ]) begin
            found_s = 1'b1;
            win_s   = PTR_W'((int'(eff_ptr_s) + k) % NREQ);
         end else begin
            found_s = found_s;
         end
      end
      if (found_s) begin
         grant_s = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
      end else begin
         grant_s = {NREQ{1'b0}};
      end
      if (win_s == PTR_W'(NREQ - 1)) begin
         ptr_next_s = {PTR_W{1'b0}};
      end else begin
         ptr_next_s = win_s + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      sel_in_s  = $signed(op_in[slice_lo(int'(win_s), BITSIZE) +: BITSIZE]);
      sel_att_s = op_att[slice_lo(int'(win_s), BITSIZE) +: BITSIZE];
   end

   // The next tag stages are grant_s plus every stage except the last one
   always_comb begin
      busy_next_s = |grant_s;
      for (int k = 0; k < LAT - 1; k++) begin
         busy_next_s = busy_next_s | (|tag_r[k]);
      end
   end

   // Arbiter state: frame edge detect, pointer, grant, operand capture, overrun
   always_ff @(posedge bclk or posedge rst) begin
      if (rst) begin
         lrclk_r   <= 1'b0;
         ptr_r     <= {PTR_W{1'b0}};
         gnt       <= {NREQ{1'b0}};
         mul_in_r  <= {BITSIZE{1'b0}};
         mul_att_r <= {BITSIZE{1'b0}};
         overrun   <= 1'b0;
      end else begin
         lrclk_r <= lrclk;
         gnt     <= grant_s;
         if (found_s) begin
            ptr_r     <= ptr_next_s;
            mul_in_r  <= sel_in_s;
            mul_att_r <= sel_att_s;
         end else begin
            ptr_r     <= ptr_r;
            mul_in_r  <= mul_in_r;
            mul_att_r <= mul_att_r;
         end
         // Uses req as presented, before any grant issued in this cycle
         if (frame_start_s && (|req)) begin
            overrun <= 1'b1;
         end else begin
            overrun <= overrun;
         end
      end
   end

   // Tag pipeline tracking result ownership; its exit drives rsp_valid
   always_ff @(posedge bclk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < LAT; k++) begin
            tag_r[k] <= {NREQ{1'b0}};
         end
         rsp_valid <= {NREQ{1'b0}};
         busy      <= 1'b0;
      end else begin
         tag_r[0] <= grant_s;
         for (int k = 1; k < LAT; k++) begin
            tag_r[k] <= tag_r[k-1];
         end
         rsp_valid <= tag_r[LAT-1];
         busy      <= busy_next_s;
      end
   end

   attenuator #(
      .BITSIZE (BITSIZE),
      .LAT     (LAT)
   ) A1 (
      .clk    (bclk),
      .rst    (rst),
      .sample (mul_in_r),
      .att    (mul_att_r),
      .result (rsp_data)
   );

`ifdef ATTENUATOR_ARBITER_STATS_EN
   localparam logic [STAT_W-1:0] STAT_MAX = 8'hFF;
   logic [STAT_W-1:0] frame_cnt_r;

   // Per-frame grant counter; a grant in the frame-start cycle counts toward the new frame
   always_ff @(posedge bclk or posedge rst) begin
      if (rst) begin
         frame_cnt_r <= {STAT_W{1'b0}};
         grant_count <= {STAT_W{1'b0}};
      end else if (frame_start_s) begin
         grant_count <= frame_cnt_r;
         frame_cnt_r <= found_s ? 8'd1 : 8'd0;
      end else if (found_s && (frame_cnt_r != STAT_MAX)) begin
         grant_count <= grant_count;
         frame_cnt_r <= frame_cnt_r + 8'd1;
      end else begin
         grant_count <= grant_count;
         frame_cnt_r <= frame_cnt_r;
      end
   end
`else
   assign grant_count = 8'h00;
`endif

endmodule

// File: tb/tb_attenuator_arbiter.sv
// -----------------------------------------------------------------------------
// tb_attenuator_arbiter
// Self-checking bench for attenuator_arbiter (BITSIZE=16, NREQ=4, LAT=1).
// A vector table drives the per-cycle req/lrclk and expected gnt/busy/overrun.
// Hand sequences cover single-request latency, mid-operation reset and
// per-frame statistics. Every expected grant pushes its result onto a
// scoreboard that a monitor drains against rsp_valid/rsp_data.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_attenuator_arbiter;

   localparam int BITSIZE = 16;
   localparam int NREQ    = 4;
   localparam int LAT     = 1;
`ifdef ATTENUATOR_ARBITER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic                      bclk;
   logic                      rst;
   logic                      lrclk;
   logic [NREQ-1:0]           req;
   logic [NREQ*BITSIZE-1:0]   op_in;
   logic [NREQ*BITSIZE-1:0]   op_att;
   logic [NREQ-1:0]           gnt;
   logic [NREQ-1:0]           rsp_valid;
   logic signed [BITSIZE-1:0] rsp_data;
   logic                      busy;
   logic                      overrun;
   logic [7:0]                grant_count;

   attenuator_arbiter #(.BITSIZE(BITSIZE), .NREQ(NREQ), .LAT(LAT)) dut (
      .bclk(bclk), .rst(rst), .lrclk(lrclk), .req(req), .op_in(op_in),
      .op_att(op_att), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .busy(busy), .overrun(overrun), .grant_count(grant_count)
   );

   typedef struct {
      logic [3:0] req;
      logic       lrclk;
      logic [3:0] gnt;
      logic       busy;
      logic       ovr;
   } vec_t;

   typedef struct {
      int         due;
      logic [3:0] tag;
      logic [15:0] data;
   } exp_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   exp_t sb_q[$];
   vec_t vecs[19];
   logic signed [15:0] tb_in[4];
   logic [15:0]        tb_att[4];

   initial bclk = 1'b0;
   always #5 bclk = ~bclk;

   always @(posedge bclk) cyc <= cyc + 1;

   // Reference attenuator: sample*att/2^15, saturated to signed 16 bits
   function automatic logic [15:0] att_ref(input logic signed [15:0] s, input logic [15:0] a);
      longint p;
      p = longint'(s) * longint'(a);
      p = p >>> 15;
      if (p > 32767) return 16'h7FFF;
      else if (p < -32768) return 16'h8000;
      else return p[15:0];
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One bench cycle: apply inputs, clock, compare gnt, queue expected result
   task automatic step(input logic [3:0] r, input logic l, input logic [3:0] eg, input string nm);
      req   = r;
      lrclk = l;
      @(posedge bclk);
      #1;
      check({nm, " gnt"}, {28'd0, gnt}, {28'd0, eg});
      for (int i = 0; i < NREQ; i++) begin
         if (eg[i]) sb_q.push_back('{cyc + LAT, eg, att_ref(tb_in[i], tb_att[i])});
      end
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, " gnt"},         {28'd0, gnt},       32'd0);
      check({nm, " rsp_valid"},   {28'd0, rsp_valid}, 32'd0);
      check({nm, " rsp_data"},    {16'd0, rsp_data},  32'd0);
      check({nm, " busy"},        {31'd0, busy},      32'd0);
      check({nm, " overrun"},     {31'd0, overrun},   32'd0);
      check({nm, " grant_count"}, {24'd0, grant_count}, 32'd0);
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      req   = 4'b0000;
      lrclk = 1'b0;
      @(posedge bclk);
      @(posedge bclk);
      #1;
      check_all_zero("reset");
      sb_q.delete();
      rst = 1'b0;
   endtask

   // Scoreboard monitor: result due this cycle, otherwise rsp_valid must be idle
   always @(posedge bclk) begin
      #1;
      if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
         check("rsp_valid", {28'd0, rsp_valid}, {28'd0, sb_q[0].tag});
         check("rsp_data",  {16'd0, rsp_data},  {16'd0, sb_q[0].data});
         void'(sb_q.pop_front());
      end else begin
         check("rsp_valid idle", {28'd0, rsp_valid}, 32'd0);
      end
   end

   initial begin
      // Operands: plain, unity gain, positive saturation, negative saturation
      tb_in[0] = 16'sd16000;  tb_att[0] = 16'h4000;
      tb_in[1] = -16'sd12345; tb_att[1] = 16'h8000;
      tb_in[2] = 16'sd30000;  tb_att[2] = 16'hFFFF;
      tb_in[3] = -16'sd32768; tb_att[3] = 16'hC000;
      op_in  = {tb_in[3], tb_in[2], tb_in[1], tb_in[0]};
      op_att = {tb_att[3], tb_att[2], tb_att[1], tb_att[0]};

      //           req     lrclk  gnt     busy  ovr
      vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0};
      vecs[1]  = '{4'b1110, 1'b0, 4'b0010, 1'b1, 1'b0};
      vecs[2]  = '{4'b1100, 1'b0, 4'b0100, 1'b1, 1'b0};
      vecs[3]  = '{4'b1000, 1'b0, 4'b1000, 1'b1, 1'b0};
      vecs[4]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
      vecs[5]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0};
      vecs[6]  = '{4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0};
      vecs[7]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0};
      vecs[8]  = '{4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0};
      vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
      vecs[10] = '{4'b0011, 1'b0, 4'b0001, 1'b1, 1'b0};
      vecs[11] = '{4'b0011, 1'b0, 4'b0010, 1'b1, 1'b0};
      vecs[12] = '{4'b0011, 1'b0, 4'b0001, 1'b1, 1'b0};
      vecs[13] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
      vecs[14] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0};
      vecs[15] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
      vecs[16] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 1'b1};
      vecs[17] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 1'b1};
      vecs[18] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1};

      do_reset();

      for (int v = 0; v < 19; v++) begin
         step(vecs[v].req, vecs[v].lrclk, vecs[v].gnt, $sformatf("vec%0d", v));
         check($sformatf("vec%0d busy", v),    {31'd0, busy},    {31'd0, vecs[v].busy});
         check($sformatf("vec%0d overrun", v), {31'd0, overrun}, {31'd0, vecs[v].ovr});
      end

      // Single requester: one-cycle grant, busy while in flight, result next cycle
      step(4'b0001, 1'b1, 4'b0001, "single");
      check("single busy", {31'd0, busy}, 32'd1);
      step(4'b0000, 1'b1, 4'b0000, "single idle");
      check("single busy drop", {31'd0, busy}, 32'd0);
      check("single data", {16'd0, rsp_data}, {16'd0, 16'sd8000});

      // Reset one cycle after a grant discards the in-flight result
      step(4'b0001, 1'b1, 4'b0001, "midrst");
      req   = 4'b0000;
      lrclk = 1'b0;
      rst   = 1'b1;
      #2;
      check_all_zero("midrst");
      sb_q.delete();
      @(posedge bclk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) step(4'b0000, 1'b0, 4'b0000, "post rst");

      // Frame statistics: 5 grants, then 300 grants (saturates)
      step(4'b0000, 1'b1, 4'b0000, "fs0");
      for (int k = 0; k < 10; k++)
         step(4'b0001, 1'b1, (k % 2 == 0) ? 4'b0001 : 4'b0000, "five");
      step(4'b0000, 1'b0, 4'b0000, "fs1 low");
      step(4'b0000, 1'b1, 4'b0000, "fs1");
      check("grant_count 5", {24'd0, grant_count}, STATS ? 32'd5 : 32'd0);
      for (int k = 0; k < 300; k++)
         step(4'b0011, 1'b1, (k % 2 == 0) ? 4'b0010 : 4'b0001, "many");
      step(4'b0000, 1'b1, 4'b0000, "many end");
      step(4'b0000, 1'b0, 4'b0000, "fs2 low");
      step(4'b0000, 1'b1, 4'b0000, "fs2");
      check("grant_count 255", {24'd0, grant_count}, STATS ? 32'd255 : 32'd0);
      check("overrun clean frames", {31'd0, overrun}, 32'd0);

      step(4'b0000, 1'b1, 4'b0000, "drain");
      check("scoreboard empty", sb_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
